// File: rtl/rca_lsq.sv
// rca_lsq: load/store queue between the RCA grid rows and the shared LSU.
// Same-cycle row requests are pushed in ascending row order into a FIFO and
// issued one at a time. A load blocks further issue until its data returns to
// the row that asked for it, so memory order is strict program order.
module rca_lsq #(
  parameter int XLEN          = 32,
  parameter int GRID_NUM_ROWS = 4,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [GRID_NUM_ROWS-1:0][XLEN-1:0]  grid_addr,
  input  logic [GRID_NUM_ROWS-1:0][XLEN-1:0]  grid_data,
  input  logic [GRID_NUM_ROWS-1:0][2:0]       grid_fn3,
  input  logic [GRID_NUM_ROWS-1:0]            grid_load,
  input  logic [GRID_NUM_ROWS-1:0]            grid_store,
  input  logic [GRID_NUM_ROWS-1:0]            grid_new_request,
  output logic                                grid_fifo_full,
  output logic [GRID_NUM_ROWS-1:0]            grid_load_complete,
  output logic [XLEN-1:0]                     grid_load_data,
  output logic [XLEN-1:0]                     lsu_rs1,
  output logic [XLEN-1:0]                     lsu_rs2,
  output logic [2:0]                          lsu_fn3,
  output logic                                lsu_load,
  output logic                                lsu_store,
  output logic                                lsu_rca_lsu_lock,
  input  logic                                lsu_lsu_ready,
  input  logic                                lsu_load_complete,
  input  logic [XLEN-1:0]                     lsu_load_data
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int RW = (GRID_NUM_ROWS > 1) ? $clog2(GRID_NUM_ROWS) : 1;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
    logic [2:0]      fn3;
    logic            load;
    logic [RW-1:0]   row;
  } entry_t;

  entry_t                     mem_q [FIFO_DEPTH];
  entry_t                     mem_d [FIFO_DEPTH];
  logic [PW-1:0]              head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]              count_q, count_d, npush;
  logic                       pend_q, pend_d;
  logic [RW-1:0]              prow_q, prow_d;
  logic                       lock_q, lock_d;
  logic [GRID_NUM_ROWS-1:0]   gc_q, gc_d;
  logic [XLEN-1:0]            gd_q, gd_d;
  logic [GRID_NUM_ROWS-1:0]   req_vld;
  logic                       eligible, fire;
  entry_t                     head_e;

  // a row with both or neither of load/store set is not a request
  assign req_vld = grid_new_request & (grid_load ^ grid_store);

  // full is decoded from the registered count only, never from grid inputs
  assign grid_fifo_full = (CW'(FIFO_DEPTH) - count_q) < CW'(GRID_NUM_ROWS);

  assign head_e   = mem_q[head_q];
  assign eligible = (count_q != '0) && !pend_q;
  assign fire     = eligible && lsu_lsu_ready;

  assign lsu_rs1            = head_e.addr;
  assign lsu_rs2            = head_e.data;
  assign lsu_fn3            = head_e.fn3;
  assign lsu_load           = eligible && head_e.load;
  assign lsu_store          = eligible && !head_e.load;
  assign lsu_rca_lsu_lock   = lock_q;
  assign grid_load_complete = gc_q;
  assign grid_load_data     = gd_q;

  // next-state: push valid rows in row order, pop on issue, track load return
  always_comb begin
    mem_d  = mem_q;
    npush  = '0;
    pend_d = pend_q;
    prow_d = prow_q;
    gc_d   = '0;
    gd_d   = gd_q;
    if (!grid_fifo_full) begin
      for (int r = 0; r < GRID_NUM_ROWS; r++) begin
        if (req_vld[r]) begin
          mem_d[tail_q + npush[PW-1:0]] = '{addr: grid_addr[r], data: grid_data[r],
                                            fn3: grid_fn3[r], load: grid_load[r],
                                            row: RW'(r)};
          npush = npush + CW'(1);
        end
      end
    end
    // completion and a new load issue never coincide: issue needs !pend_q
    if (lsu_load_complete && pend_q) begin
      gc_d[prow_q] = 1'b1;
      gd_d         = lsu_load_data;
      pend_d       = 1'b0;
    end
    if (fire && head_e.load) begin
      pend_d = 1'b1;
      prow_d = head_e.row;
    end
    head_d  = head_q + PW'(fire);
    tail_d  = tail_q + npush[PW-1:0];
    count_d = count_q + npush - CW'(fire);
    lock_d  = (count_d != '0) || pend_d;
  end

  // state registers; reset discards all entries and any pending load
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      pend_q  <= 1'b0;
      prow_q  <= '0;
      lock_q  <= 1'b0;
      gc_q    <= '0;
      gd_q    <= '0;
    end else begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= mem_d[i];
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      pend_q  <= pend_d;
      prow_q  <= prow_d;
      lock_q  <= lock_d;
      gc_q    <= gc_d;
      gd_q    <= gd_d;
    end
  end

endmodule
